// File: rtl/boot_loader_pkg.sv
// Shared constants for the boot image copier: FSM state encoding and default widths.
package boot_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STORE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_IMAGE_WORDS = 256;

endpackage

// File: rtl/boot_loader_if.sv
// ROM read port and RAM write port of the boot loader, both req/ack handshakes.
interface boot_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  rom_req;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic                  rom_ack;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_ack;

    modport master (
        output rom_req, rom_addr, ram_we, ram_addr, ram_wdata,
        input  rom_ack, rom_data, ram_ack
    );

    modport slave (
        input  rom_req, rom_addr, ram_we, ram_addr, ram_wdata,
        output rom_ack, rom_data, ram_ack
    );
endinterface

// File: rtl/boot_loader.sv
// Copies IMAGE_WORDS words from boot ROM to RAM after the bootstrap start pulse,
// holding the CPU in reset until the last word has been written.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int IMAGE_WORDS = DEF_IMAGE_WORDS,
    parameter int ROM_BASE    = 0,
    parameter int RAM_BASE    = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    boot_loader_if.master  bus,
    output logic           cpu_rst,
    output logic           busy,
    output logic           done
);

    // One extra index bit so a full 2^ADDR_WIDTH image still reaches its last word.
    localparam int IW = ADDR_WIDTH + 1;
    localparam logic [IW-1:0]         LAST  = IW'(IMAGE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ROM_B = ADDR_WIDTH'(ROM_BASE);
    localparam logic [ADDR_WIDTH-1:0] RAM_B = ADDR_WIDTH'(RAM_BASE);

    state_t                state;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_nxt;
    logic [DATA_WIDTH-1:0] data_q;

    assign idx_nxt       = idx + IW'(1);
    assign bus.ram_wdata = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            data_q       <= '0;
            cpu_rst      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.rom_req  <= 1'b0;
            bus.rom_addr <= '0;
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (IMAGE_WORDS == 0) begin
                            state   <= FINISH;
                            cpu_rst <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            idx          <= '0;
                            busy         <= 1'b1;
                            bus.rom_req  <= 1'b1;
                            bus.rom_addr <= ROM_B;
                        end
                    end
                end
                FETCH: begin
                    if (bus.rom_ack) begin
                        state        <= STORE;
                        data_q       <= bus.rom_data;
                        bus.rom_req  <= 1'b0;
                        bus.ram_we   <= 1'b1;
                        bus.ram_addr <= RAM_B + idx[ADDR_WIDTH-1:0];
                    end
                end
                STORE: begin
                    if (bus.ram_ack) begin
                        bus.ram_we <= 1'b0;
                        if (idx == LAST) begin
                            state   <= FINISH;
                            busy    <= 1'b0;
                            cpu_rst <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            idx          <= idx_nxt;
                            bus.rom_req  <= 1'b1;
                            bus.rom_addr <= ROM_B + idx_nxt[ADDR_WIDTH-1:0];
                        end
                    end
                end
                FINISH: begin
                    // Terminal until rst.
                    cpu_rst <= 1'b0;
                    done    <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: three instances (4-word, wrapping 3-word, empty image)
// served by a ROM/RAM responder with programmable ack delays.
module tb_boot_loader;
    import boot_loader_pkg::*;

    localparam int AW = 8, DW = 8, N = 3, LOGSZ = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] start = '0;
    logic [N-1:0] cpu_rst, busy, done;
    logic [N-1:0] stray = '0;

    logic [N-1:0]         rom_req_v, ram_we_v;
    logic [N-1:0][AW-1:0] rom_addr_v, ram_addr_v;
    logic [N-1:0][DW-1:0] ram_wdata_v;
    logic [N-1:0]         rom_ack_v = '0, ram_ack_v = '0;
    logic [N-1:0][DW-1:0] rom_data_v = '0;

    int n_cmp = 0, n_bad = 0;
    int rom_dly[N], ram_dly[N];
    int wr_cnt[N], rd_cnt[N], unstable[N], req_seen[N];
    int rc[N], wc[N];
    logic [AW-1:0] wr_addr[N][LOGSZ];
    logic [DW-1:0] wr_data[N][LOGSZ];
    logic [AW-1:0] rd_addr[N][LOGSZ];
    logic [AW-1:0] hold_ra[N], hold_wa[N];
    logic [DW-1:0] hold_wd[N];

    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g
        boot_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();
        boot_loader #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .IMAGE_WORDS(i == 0 ? 4 : (i == 1 ? 3 : 0)),
            .ROM_BASE   (i == 1 ? 254 : 0),
            .RAM_BASE   (i == 1 ? 255 : 0)
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .start  (start[i]),
            .bus    (bif),
            .cpu_rst(cpu_rst[i]),
            .busy   (busy[i]),
            .done   (done[i])
        );
        assign rom_req_v[i]   = bif.rom_req;
        assign rom_addr_v[i]  = bif.rom_addr;
        assign ram_we_v[i]    = bif.ram_we;
        assign ram_addr_v[i]  = bif.ram_addr;
        assign ram_wdata_v[i] = bif.ram_wdata;
        assign bif.rom_ack    = rom_ack_v[i] | stray[i];
        assign bif.rom_data   = rom_data_v[i];
        assign bif.ram_ack    = ram_ack_v[i] | stray[i];
    end

    function automatic logic [DW-1:0] rom_img(input logic [AW-1:0] a);
        case (a)
            8'h00: return 8'h11;
            8'h01: return 8'h22;
            8'h02: return 8'h33;
            8'h03: return 8'h44;
            default: return a ^ 8'hA5;
        endcase
    endfunction

    // Responder: acks after the programmed number of wait cycles, logs accepted
    // transfers and any address/data change while a request is pending.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rom_req_v[i] || ram_we_v[i]) req_seen[i]++;
            rom_ack_v[i]  = 1'b0;
            rom_data_v[i] = '0;
            if (rom_req_v[i]) begin
                if (rc[i] == 0) hold_ra[i] = rom_addr_v[i];
                else if (rom_addr_v[i] !== hold_ra[i]) unstable[i]++;
                if (rc[i] >= rom_dly[i]) begin
                    rom_ack_v[i]  = 1'b1;
                    rom_data_v[i] = rom_img(rom_addr_v[i]);
                    rd_addr[i][rd_cnt[i] % LOGSZ] = rom_addr_v[i];
                    rd_cnt[i]++;
                    rc[i] = 0;
                end else rc[i]++;
            end else rc[i] = 0;
            ram_ack_v[i] = 1'b0;
            if (ram_we_v[i]) begin
                if (wc[i] == 0) begin
                    hold_wa[i] = ram_addr_v[i];
                    hold_wd[i] = ram_wdata_v[i];
                end else if (ram_addr_v[i] !== hold_wa[i] || ram_wdata_v[i] !== hold_wd[i]) unstable[i]++;
                if (wc[i] >= ram_dly[i]) begin
                    ram_ack_v[i] = 1'b1;
                    wr_addr[i][wr_cnt[i] % LOGSZ] = ram_addr_v[i];
                    wr_data[i][wr_cnt[i] % LOGSZ] = ram_wdata_v[i];
                    wr_cnt[i]++;
                    wc[i] = 0;
                end else wc[i]++;
            end else wc[i] = 0;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if ({cpu_rst[i], busy[i], done[i], rom_req_v[i], ram_we_v[i]} !== 5'b10000) begin
                    n_bad++;
                    $display("FAIL reset_ctl[%0d] phase%0d: got %b want 10000", i, p,
                             {cpu_rst[i], busy[i], done[i], rom_req_v[i], ram_we_v[i]});
                end
                n_cmp++;
                if ({rom_addr_v[i], ram_addr_v[i], ram_wdata_v[i]} !== 24'h0) begin
                    n_bad++;
                    $display("FAIL reset_bus[%0d] phase%0d: got %h want 000000", i, p,
                             {rom_addr_v[i], ram_addr_v[i], ram_wdata_v[i]});
                end
            end
            rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_zero_wait();
        logic [DW-1:0] exp_d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int b = wr_cnt[0];
        int fall = 0;
        rom_dly[0] = 0; ram_dly[0] = 0;
        start[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            @(negedge clk);
            start[0] = 1'b0;
            if (e == 1) begin
                n_cmp++;
                if ({busy[0], rom_req_v[0], rom_addr_v[0]} !== {2'b11, 8'h00}) begin
                    n_bad++;
                    $display("FAIL zw_first_fetch: got busy/req/addr %b%b/%h want 11/00", busy[0], rom_req_v[0], rom_addr_v[0]);
                end
            end
            if (fall == 0 && cpu_rst[0] === 1'b0) fall = e;
        end
        n_cmp++;
        if (fall != 9) begin n_bad++; $display("FAIL zw_cpu_rst_edge: got %0d want 9", fall); end
        n_cmp++;
        if (wr_cnt[0] - b != 4) begin n_bad++; $display("FAIL zw_write_count: got %0d want 4", wr_cnt[0] - b); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (wr_addr[0][(b + k) % LOGSZ] !== AW'(k) || wr_data[0][(b + k) % LOGSZ] !== exp_d[k]) begin
                n_bad++;
                $display("FAIL zw_write[%0d]: got %h:%h want %h:%h", k, wr_addr[0][(b + k) % LOGSZ],
                         wr_data[0][(b + k) % LOGSZ], AW'(k), exp_d[k]);
            end
        end
        n_cmp++;
        if ({cpu_rst[0], busy[0], done[0]} !== 3'b001) begin
            n_bad++;
            $display("FAIL zw_final: got cpu_rst/busy/done %b want 001", {cpu_rst[0], busy[0], done[0]});
        end
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] exp_d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int b, u, fall;
        do_reset();
        rom_dly[0] = 3; ram_dly[0] = 2;
        b = wr_cnt[0]; u = unstable[0]; fall = 0;
        start[0] = 1'b1;
        for (int e = 1; e <= 60 && fall == 0; e++) begin
            @(posedge clk);
            @(negedge clk);
            start[0] = 1'b0;
            if (cpu_rst[0] === 1'b0) fall = e;
        end
        n_cmp++;
        if (fall != 29) begin n_bad++; $display("FAIL ws_cpu_rst_edge: got %0d want 29", fall); end
        n_cmp++;
        if (unstable[0] != u) begin n_bad++; $display("FAIL ws_stability: got %0d changes want 0", unstable[0] - u); end
        n_cmp++;
        if (wr_cnt[0] - b != 4) begin n_bad++; $display("FAIL ws_write_count: got %0d want 4", wr_cnt[0] - b); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (wr_addr[0][(b + k) % LOGSZ] !== AW'(k) || wr_data[0][(b + k) % LOGSZ] !== exp_d[k]) begin
                n_bad++;
                $display("FAIL ws_write[%0d]: got %h:%h want %h:%h", k, wr_addr[0][(b + k) % LOGSZ],
                         wr_data[0][(b + k) % LOGSZ], AW'(k), exp_d[k]);
            end
        end
        rom_dly[0] = 0; ram_dly[0] = 0;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_ra[3] = '{8'hFE, 8'hFF, 8'h00};
        logic [AW-1:0] exp_wa[3] = '{8'hFF, 8'h00, 8'h01};
        logic [DW-1:0] exp_wd[3] = '{8'h5B, 8'h5A, 8'h11};
        int bw = wr_cnt[1];
        int br = rd_cnt[1];
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        for (int k = 0; k < 50 && done[1] !== 1'b1; k++) @(negedge clk);
        n_cmp++;
        if (done[1] !== 1'b1) begin n_bad++; $display("FAIL wrap_done: got %b want 1", done[1]); end
        n_cmp++;
        if (rd_cnt[1] - br != 3 || wr_cnt[1] - bw != 3) begin
            n_bad++;
            $display("FAIL wrap_counts: got rd %0d wr %0d want 3 3", rd_cnt[1] - br, wr_cnt[1] - bw);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (rd_addr[1][(br + k) % LOGSZ] !== exp_ra[k] || wr_addr[1][(bw + k) % LOGSZ] !== exp_wa[k] ||
                wr_data[1][(bw + k) % LOGSZ] !== exp_wd[k]) begin
                n_bad++;
                $display("FAIL wrap_word[%0d]: got rom %h ram %h:%h want rom %h ram %h:%h", k,
                         rd_addr[1][(br + k) % LOGSZ], wr_addr[1][(bw + k) % LOGSZ], wr_data[1][(bw + k) % LOGSZ],
                         exp_ra[k], exp_wa[k], exp_wd[k]);
            end
        end
    endtask

    task automatic test_rst_mid();
        int b, b2;
        bit found = 0;
        do_reset();
        rom_dly[0] = 0; ram_dly[0] = 6;
        b = wr_cnt[0];
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (ram_we_v[0] === 1'b1 && ram_addr_v[0] === 8'h02) found = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL rm_reach_store2: got timeout want STORE of word 2"); end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({cpu_rst[0], ram_we_v[0], busy[0], done[0]} !== 4'b1000) begin
            n_bad++;
            $display("FAIL rm_async_abort: got cpu_rst/we/busy/done %b want 1000", {cpu_rst[0], ram_we_v[0], busy[0], done[0]});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ram_dly[0] = 0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (wr_cnt[0] - b != 2 || rom_req_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_no_more_writes: got %0d writes req %b want 2 writes req 0", wr_cnt[0] - b, rom_req_v[0]);
        end
        b2 = wr_cnt[0];
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int k = 0; k < 50 && done[0] !== 1'b1; k++) @(negedge clk);
        n_cmp++;
        if (wr_cnt[0] - b2 != 4 || wr_addr[0][b2 % LOGSZ] !== 8'h00 || wr_data[0][(b2 + 3) % LOGSZ] !== 8'h44) begin
            n_bad++;
            $display("FAIL rm_recopy: got %0d writes first addr %h last data %h want 4 00 44",
                     wr_cnt[0] - b2, wr_addr[0][b2 % LOGSZ], wr_data[0][(b2 + 3) % LOGSZ]);
        end
    endtask

    task automatic test_ignored();
        int b;
        do_reset();
        rom_dly[0] = 1; ram_dly[0] = 1;
        b = wr_cnt[0];
        stray[0] = 1'b1;
        repeat (3) @(negedge clk);
        stray[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cpu_rst[0], busy[0], rom_req_v[0], ram_we_v[0]} !== 4'b1000 || wr_cnt[0] != b) begin
            n_bad++;
            $display("FAIL ig_idle_acks: got cpu_rst/busy/req/we %b writes %0d want 1000 0",
                     {cpu_rst[0], busy[0], rom_req_v[0], ram_we_v[0]}, wr_cnt[0] - b);
        end
        start[0] = 1'b1;
        repeat (3) @(negedge clk);
        start[0] = 1'b0;
        for (int k = 0; k < 50 && wr_cnt[0] - b < 2; k++) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int k = 0; k < 50 && done[0] !== 1'b1; k++) @(negedge clk);
        n_cmp++;
        if (done[0] !== 1'b1 || wr_cnt[0] - b != 4) begin
            n_bad++;
            $display("FAIL ig_restart: got done %b writes %0d want 1 4", done[0], wr_cnt[0] - b);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (wr_addr[0][(b + k) % LOGSZ] !== AW'(k)) begin
                n_bad++;
                $display("FAIL ig_write_addr[%0d]: got %h want %h", k, wr_addr[0][(b + k) % LOGSZ], AW'(k));
            end
        end
        stray[0] = 1'b1;
        repeat (2) @(negedge clk);
        stray[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cpu_rst[0], busy[0], done[0], rom_req_v[0]} !== 4'b0010 || wr_cnt[0] - b != 4) begin
            n_bad++;
            $display("FAIL ig_finish_acks: got cpu_rst/busy/done/req %b writes %0d want 0010 4",
                     {cpu_rst[0], busy[0], done[0], rom_req_v[0]}, wr_cnt[0] - b);
        end
    endtask

    task automatic test_zero_words();
        do_reset();
        n_cmp++;
        if ({cpu_rst[2], done[2]} !== 2'b10) begin
            n_bad++;
            $display("FAIL zwd_before: got cpu_rst/done %b want 10", {cpu_rst[2], done[2]});
        end
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        n_cmp++;
        if ({cpu_rst[2], busy[2], done[2]} !== 3'b001) begin
            n_bad++;
            $display("FAIL zwd_one_edge: got cpu_rst/busy/done %b want 001", {cpu_rst[2], busy[2], done[2]});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (req_seen[2] != 0 || done[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL zwd_no_traffic: got %0d req/we cycles done %b want 0 1", req_seen[2], done[2]);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_wrap();
        test_rst_mid();
        test_ignored();
        test_zero_words();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
